// File: rtl/sim_status_monitor.sv
// End-of-test detector: watches per-channel status words, latches PASS/FAIL/TIMEOUT,
// drains for DrainCycles and then pulses finish_o once.
module sim_status_monitor #(
    parameter int unsigned      Width         = 32,
    parameter int unsigned      NumChannels   = 2,
    parameter logic [Width-1:0] PassCode      = Width'(32'hDEADBEEF),
    parameter logic [Width-1:0] FailCode      = Width'(32'hBAADF00D),
    parameter int unsigned      StableCycles  = 1,
    parameter int unsigned      DrainCycles   = 7,
    parameter int unsigned      TimeoutCycles = 0,
    localparam int unsigned     ChanW         = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    localparam int unsigned     CntW          = $clog2(StableCycles + 1),
    localparam int unsigned     DrainW        = $clog2(DrainCycles + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumChannels-1:0]       en_i,
    input  logic [NumChannels*Width-1:0] code_i,
    output logic                         done_o,
    output logic                         pass_o,
    output logic                         fail_o,
    output logic                         timeout_o,
    output logic [ChanW-1:0]             fail_chan_o,
    output logic                         finish_o,
    output logic [31:0]                  cycle_count_o
);

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e                 r_state;
    logic [Width-1:0]       r_prev [NumChannels];
    logic [CntW-1:0]        r_cnt [NumChannels];
    logic [NumChannels-1:0] r_pass_seen;
    logic [DrainW-1:0]      r_drain_cnt;
    logic [31:0]            r_cycle_count;
    logic                   r_done;
    logic                   r_pass;
    logic                   r_fail;
    logic                   r_timeout;
    logic                   r_finish;
    logic [ChanW-1:0]       r_fail_chan;

    logic [Width-1:0]       w_code [NumChannels];
    logic [CntW-1:0]        w_cnt [NumChannels];
    logic [NumChannels-1:0] w_qual;
    logic [NumChannels-1:0] w_fail_hit;
    logic [NumChannels-1:0] w_pass_seen_d;
    logic [ChanW-1:0]       w_fail_chan;
    logic                   w_fail_any;
    logic                   w_all_pass;
    logic                   w_timeout_hit;

    // w_cnt is this cycle's run length minus one; it saturates so the compare stays valid.
    always_comb begin
        for (int k = 0; k < int'(NumChannels); k++) begin
            w_code[k] = code_i[k*Width +: Width];
            w_cnt[k]  = '0;
            if (w_code[k] == r_prev[k]) begin
                if (r_cnt[k] == CntW'(StableCycles)) begin
                    w_cnt[k] = r_cnt[k];
                end else begin
                    w_cnt[k] = r_cnt[k] + CntW'(1);
                end
            end
            w_qual[k]        = en_i[k] && ((32'(w_cnt[k]) + 32'd1) >= StableCycles);
            w_fail_hit[k]    = w_qual[k] && (w_code[k] == FailCode);
            w_pass_seen_d[k] = r_pass_seen[k] || (w_qual[k] && (w_code[k] == PassCode));
        end
    end

    always_comb begin
        w_fail_chan = '0;
        for (int k = int'(NumChannels) - 1; k >= 0; k--) begin
            if (w_fail_hit[k]) begin
                w_fail_chan = ChanW'(k);
            end
        end
        w_fail_any    = |w_fail_hit;
        // Disabled channels count as passed, but an all-disabled monitor never passes.
        w_all_pass    = (|en_i) && (&(w_pass_seen_d | ~en_i));
        w_timeout_hit = (TimeoutCycles != 0) && (r_cycle_count == 32'(TimeoutCycles - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(NumChannels); k++) begin
                r_prev[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NumChannels); k++) begin
                r_prev[k] <= w_code[k];
                r_cnt[k]  <= en_i[k] ? w_cnt[k] : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= StRun;
            r_pass_seen   <= '0;
            r_drain_cnt   <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_finish      <= 1'b0;
            r_fail_chan   <= '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    r_pass_seen <= w_pass_seen_d;
                    if (w_fail_any || w_all_pass || w_timeout_hit) begin
                        r_done      <= 1'b1;
                        r_state     <= StDrain;
                        r_drain_cnt <= '0;
                        r_finish    <= (DrainCycles == 1);
                        if (w_fail_any) begin
                            r_fail      <= 1'b1;
                            r_fail_chan <= w_fail_chan;
                        end else if (w_all_pass) begin
                            r_pass <= 1'b1;
                        end else begin
                            r_timeout <= 1'b1;
                        end
                    end else if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + 32'd1;
                    end
                end
                StDrain: begin
                    if (r_drain_cnt == DrainW'(DrainCycles - 1)) begin
                        r_state  <= StDone;
                        r_finish <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DrainW'(1);
                        r_finish    <= ((r_drain_cnt + DrainW'(1)) == DrainW'(DrainCycles - 1));
                    end
                end
                StDone: begin
                    r_finish <= 1'b0;
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    assign done_o        = r_done;
    assign pass_o        = r_pass;
    assign fail_o        = r_fail;
    assign timeout_o     = r_timeout;
    assign fail_chan_o   = r_fail_chan;
    assign finish_o      = r_finish;
    assign cycle_count_o = r_cycle_count;

endmodule

// File: tb/tb_sim_status_monitor.sv
// Bench for sim_status_monitor: two configurations share one stimulus table, and a scan-based
// reference model predicts the verdict cycle, kind and failing channel for each.
module tb_sim_status_monitor;

    localparam int          StimLen  = 120;
    localparam logic [31:0] PassVal  = 32'hDEADBEEF;
    localparam logic [31:0] FailVal  = 32'hBAADF00D;
    localparam int          ADrain   = 7;
    localparam int          BDrain   = 4;
    localparam int          BStable  = 3;
    localparam int          BTimeout = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  en = '0;
    logic [31:0] code0 = '0;
    logic [31:0] code1 = '0;
    logic [31:0] code2 = '0;

    logic        a_done, a_pass, a_fail, a_tmo, a_fin;
    logic [0:0]  a_chan;
    logic [31:0] a_cc;
    logic        b_done, b_pass, b_fail, b_tmo, b_fin;
    logic [1:0]  b_chan;
    logic [31:0] b_cc;

    logic [31:0] stim [StimLen][3];
    logic [2:0]  mask;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    sim_status_monitor #(
        .NumChannels(2)
    ) u_dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en[1:0]),
        .code_i       ({code1, code0}),
        .done_o       (a_done),
        .pass_o       (a_pass),
        .fail_o       (a_fail),
        .timeout_o    (a_tmo),
        .fail_chan_o  (a_chan),
        .finish_o     (a_fin),
        .cycle_count_o(a_cc)
    );

    sim_status_monitor #(
        .NumChannels  (3),
        .StableCycles (BStable),
        .DrainCycles  (BDrain),
        .TimeoutCycles(BTimeout)
    ) u_dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .code_i       ({code2, code1, code0}),
        .done_o       (b_done),
        .pass_o       (b_pass),
        .fail_o       (b_fail),
        .timeout_o    (b_tmo),
        .fail_chan_o  (b_chan),
        .finish_o     (b_fin),
        .cycle_count_o(b_cc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Length of the run of identical values on channel k ending at cycle t.
    function automatic int run_len(input int t, input int k);
        int n;
        n = 0;
        for (int j = t; j >= 0; j--) begin
            if (stim[j][k] != stim[t][k]) break;
            n++;
        end
        return n;
    endfunction

    // kind: 0 none, 1 pass, 2 fail, 3 timeout; tv is the decision cycle or -1.
    task automatic model(input int n, input int stable, input int timeout,
                         output int tv, output int kind, output int fch);
        bit seen [3];
        int fc;
        bit all_p;
        bit any_en;
        tv   = -1;
        kind = 0;
        fch  = 0;
        for (int k = 0; k < 3; k++) seen[k] = 1'b0;
        for (int t = 0; t < StimLen && tv < 0; t++) begin
            fc     = -1;
            all_p  = 1'b1;
            any_en = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (mask[k]) begin
                    any_en = 1'b1;
                    if (run_len(t, k) >= stable) begin
                        if (stim[t][k] == FailVal && fc < 0) fc = k;
                        if (stim[t][k] == PassVal) seen[k] = 1'b1;
                    end
                    if (!seen[k]) all_p = 1'b0;
                end
            end
            if (fc >= 0) begin
                tv = t; kind = 2; fch = fc;
            end else if (any_en && all_p) begin
                tv = t; kind = 1;
            end else if (timeout != 0 && t == timeout - 1) begin
                tv = t; kind = 3;
            end
        end
    endtask

    task automatic check_dut(input string p, input int c, input int tv, input int kind,
                             input int fch, input int drain,
                             input logic done, input logic pas, input logic fal, input logic tmo,
                             input logic fin, input logic [31:0] chan, input logic [31:0] cc);
        logic d_e;
        d_e = (tv >= 0) && (c > tv);
        check_val($sformatf("%s.done@%0d", p, c), done, d_e);
        check_val($sformatf("%s.pass@%0d", p, c), pas, d_e && kind == 1);
        check_val($sformatf("%s.fail@%0d", p, c), fal, d_e && kind == 2);
        check_val($sformatf("%s.timeout@%0d", p, c), tmo, d_e && kind == 3);
        check_val($sformatf("%s.finish@%0d", p, c), fin, (tv >= 0) && (c == tv + drain));
        check_val($sformatf("%s.fail_chan@%0d", p, c), chan, (d_e && kind == 2) ? fch : 0);
        check_val($sformatf("%s.cycle_count@%0d", p, c), cc, d_e ? tv : c);
    endtask

    task automatic run_trial(input string name, input int abort_at);
        int tva, ka, fa, tvb, kb, fb;
        model(2, 1, 0, tva, ka, fa);
        model(3, BStable, BTimeout, tvb, kb, fb);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < StimLen; c++) begin
            @(negedge clk);
            check_dut({name, ".A"}, c, tva, ka, fa, ADrain,
                      a_done, a_pass, a_fail, a_tmo, a_fin, 32'(a_chan), a_cc);
            check_dut({name, ".B"}, c, tvb, kb, fb, BDrain,
                      b_done, b_pass, b_fail, b_tmo, b_fin, 32'(b_chan), b_cc);
            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_val({name, ".A.rst_flags"}, {a_done, a_pass, a_fail, a_tmo, a_fin}, 0);
                check_val({name, ".A.rst_cc"}, a_cc, 0);
                check_val({name, ".A.rst_chan"}, 32'(a_chan), 0);
                check_val({name, ".B.rst_flags"}, {b_done, b_pass, b_fail, b_tmo, b_fin}, 0);
                check_val({name, ".B.rst_cc"}, b_cc, 0);
                break;
            end
            rst   = 1'b0;
            en    = mask;
            code0 = stim[c][0];
            code1 = stim[c][1];
            code2 = stim[c][2];
        end
    endtask

    task automatic clear_stim();
        for (int t = 0; t < StimLen; t++)
            for (int k = 0; k < 3; k++) stim[t][k] = '0;
        mask = 3'b111;
    endtask

    task automatic set_seg(input int k, input int from, input int upto, input logic [31:0] v);
        for (int t = from; t <= upto && t < StimLen; t++) stim[t][k] = v;
    endtask

    task automatic load_t1();
        clear_stim();
        set_seg(0, 10, StimLen - 1, PassVal);
        set_seg(1, 20, StimLen - 1, PassVal);
    endtask

    initial begin
        int tv6, k6, f6;
        int t, len, sel;
        logic [31:0] v;

        // Staggered pass on A; B has ch2 idle and so runs into its watchdog.
        load_t1();
        run_trial("t1", -1);

        // Fail on ch1 while ch0 passes.
        clear_stim();
        set_seg(0, 3, StimLen - 1, PassVal);
        set_seg(1, 5, StimLen - 1, FailVal);
        run_trial("t2", -1);

        // Short pass glitches on ch0, then a held pass.
        clear_stim();
        set_seg(0, 10, 11, PassVal);
        set_seg(0, 30, 32, PassVal);
        set_seg(1, 0, StimLen - 1, PassVal);
        set_seg(2, 0, StimLen - 1, PassVal);
        run_trial("t3", -1);

        // All codes idle.
        clear_stim();
        run_trial("t4", -1);

        // Fail and pass completion in the same cycle.
        clear_stim();
        set_seg(0, 2, 4, PassVal);
        set_seg(0, 5, StimLen - 1, FailVal);
        set_seg(1, 5, StimLen - 1, PassVal);
        set_seg(2, 0, StimLen - 1, PassVal);
        run_trial("t5", -1);

        // Reset in the fourth drain cycle of A, then a clean rerun.
        load_t1();
        model(2, 1, 0, tv6, k6, f6);
        run_trial("t6a", tv6 + 4);
        run_trial("t6b", -1);

        for (int r = 0; r < 25; r++) begin
            clear_stim();
            mask = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                t = 0;
                while (t < StimLen) begin
                    sel = $urandom_range(0, 9);
                    if (sel < 4)       v = '0;
                    else if (sel < 8)  v = PassVal;
                    else if (sel == 8) v = FailVal;
                    else               v = $urandom;
                    len = $urandom_range(1, 5);
                    set_seg(k, t, t + len - 1, v);
                    t += len;
                end
            end
            run_trial($sformatf("rnd%0d", r), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
